// File: rtl/s2p_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// s2p_pkg : shared types for the serial-to-parallel converter
// Rev 1.0
// ------------------------------------------------------------------
package s2p_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage
`default_nettype wire

// File: rtl/s2p_if.sv
`default_nettype none
// ------------------------------------------------------------------
// s2p_if : serial input stream plus parallel valid/ready output
// Rev 1.0
// ------------------------------------------------------------------
interface s2p_if #(
    parameter int N = 8
);
    logic         s_valid;
    logic         s_data;
    logic         s_ready;
    logic [N-1:0] p_data;
    logic         p_valid;
    logic         p_ready;

    modport slave (
        input  s_valid, s_data, p_ready,
        output s_ready, p_data, p_valid
    );

    modport master (
        output s_valid, s_data, p_ready,
        input  s_ready, p_data, p_valid
    );
endinterface
`default_nettype wire

// File: rtl/s2p.sv
`default_nettype none
// ------------------------------------------------------------------
// s2p : assembles N LSB-first serial bits into a word, one-word output buffer
// Rev 1.0
// ------------------------------------------------------------------
module s2p
    import s2p_pkg::*;
#(
    parameter int N = 8
) (
    input  wire logic clk,
    input  wire logic rstn,
    s2p_if.slave      bus
);

    localparam int                N_BITS   = $clog2(N);
    localparam logic [N_BITS-1:0] LAST_IDX = N_BITS'(N - 1);

    out_state_t        state;
    out_state_t        state_nxt;
    logic [N_BITS-1:0] count;
    logic [N-1:0]      shift_reg;
    logic [N-1:0]      word_q;
    logic              at_last;
    logic              ready;
    logic              accept;
    logic              complete;
    logic [N-1:0]      shifted;

    // s_ready depends only on registers, so p_ready never reaches it combinationally
    assign at_last  = (count == LAST_IDX);
    assign ready    = !(at_last && (state == FULL));
    assign accept   = bus.s_valid && ready;
    assign complete = accept && at_last;
    assign shifted  = {bus.s_data, shift_reg[N-1:1]};

    assign bus.s_ready = ready;
    assign bus.p_valid = (state == FULL);
    assign bus.p_data  = word_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (complete)    state_nxt = FULL;
            FULL:    if (bus.p_ready) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count     <= '0;
            shift_reg <= '0;
            word_q    <= '0;
        end else if (accept) begin
            shift_reg <= shifted;
            if (at_last) begin
                count  <= '0;
                word_q <= shifted;
            end else begin
                count  <= count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_s2p.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_s2p : directed and randomized self-checking bench for s2p (N=8, N=5)
// Rev 1.0
// ------------------------------------------------------------------
module tb_s2p;

    logic clk;
    logic rstn;
    int   tests;
    int   fails;
    int   sent[$];

    s2p_if #(.N(8)) b8 ();
    s2p_if #(.N(5)) b5 ();

    s2p #(.N(8)) dut8 (.clk(clk), .rstn(rstn), .bus(b8.slave));
    s2p #(.N(5)) dut5 (.clk(clk), .rstn(rstn), .bus(b5.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word8(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            b8.s_valid = 1'b1;
            b8.s_data  = w[i];
            tick();
        end
        b8.s_valid = 1'b0;
    endtask

    task automatic drive(input int ln, input logic sv, input logic sd, input logic pr);
        if (ln == 0) begin
            b8.s_valid = sv; b8.s_data = sd; b8.p_ready = pr;
        end else begin
            b5.s_valid = sv; b5.s_data = sd; b5.p_ready = pr;
        end
    endtask

    task automatic sample(input int ln, output logic sr, output logic pv, output logic [31:0] pd);
        if (ln == 0) begin
            sr = b8.s_ready; pv = b8.p_valid; pd = 32'(b8.p_data);
        end else begin
            sr = b5.s_ready; pv = b5.p_valid; pd = 32'(b5.p_data);
        end
    endtask

    // Word-level reference: bits accumulate until n arrive, one word may wait for the sink
    task automatic stream(input int ln, input int n);
        int          bitq[$];
        int          got[$];
        int          bits, acc, word, cyc;
        bit          full, m_rdy, take;
        logic        sv, sd, pr, sr, pv;
        logic [31:0] pd;
        bits = 0; acc = 0; word = 0; cyc = 0; full = 0;
        foreach (sent[k])
            for (int i = 0; i < n; i++) bitq.push_back((sent[k] >> i) & 1);
        while ((bitq.size() > 0 || full || bits != 0) && cyc < 4000) begin
            sv = (bitq.size() > 0) && ($urandom_range(0, 3) != 0);
            sd = sv ? 1'(bitq[0]) : 1'($urandom_range(0, 1));
            pr = 1'($urandom_range(0, 1));
            drive(ln, sv, sd, pr);
            @(negedge clk);
            sample(ln, sr, pv, pd);
            m_rdy = !(bits == n - 1 && full);
            check("s_ready", 32'(sr), 32'(m_rdy));
            check("p_valid", 32'(pv), 32'(full));
            if (full) check("p_data", pd, 32'(word));
            take = sv && m_rdy;
            if (full && pr) begin
                got.push_back(word);
                full = 0;
            end
            if (take) begin
                acc = acc | (bitq.pop_front() << bits);
                bits++;
                if (bits == n) begin
                    word = acc; full = 1; acc = 0; bits = 0;
                end
            end
            tick();
            cyc++;
        end
        drive(ln, 1'b0, 1'b0, 1'b0);
        check("stream_done", 32'(cyc < 4000), 32'd1);
        check("word_count", 32'(got.size()), 32'(sent.size()));
        for (int k = 0; k < got.size() && k < sent.size(); k++)
            check("word_order", 32'(got[k]), 32'(sent[k]));
    endtask

    initial begin
        logic [7:0] w;
        int         nvalid;
        logic [7:0] seen;
        tests = 0; fails = 0;
        rstn = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);

        // asynchronous reset with no clock edge in between
        #2 rstn = 1'b0;
        #1;
        check("rst_p_valid", 32'(b8.p_valid), 32'd0);
        check("rst_p_data",  32'(b8.p_data),  32'd0);
        check("rst_s_ready", 32'(b8.s_ready), 32'd1);
        check("rst_p_valid5", 32'(b5.p_valid), 32'd0);
        #9 rstn = 1'b1;
        tick();

        // basic word, consecutive bits
        b8.p_ready = 1'b1;
        w = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            b8.s_valid = 1'b1;
            b8.s_data  = w[i];
            if (i == 7) check("basic_pre_valid", 32'(b8.p_valid), 32'd0);
            tick();
        end
        b8.s_valid = 1'b0;
        check("basic_valid", 32'(b8.p_valid), 32'd1);
        check("basic_data",  32'(b8.p_data),  32'hA5);
        tick();
        check("basic_one_cycle", 32'(b8.p_valid), 32'd0);

        // gaps with toggling data while s_valid is low
        for (int i = 0; i < 8; i++) begin
            b8.s_valid = 1'b1;
            b8.s_data  = w[i];
            tick();
            if (i == 2 || i == 6) begin
                b8.s_valid = 1'b0;
                for (int g = 0; g < 3; g++) begin
                    b8.s_data = ~b8.s_data;
                    tick();
                end
            end
        end
        b8.s_valid = 1'b0;
        check("gap_valid", 32'(b8.p_valid), 32'd1);
        check("gap_data",  32'(b8.p_data),  32'hA5);
        tick();

        // backpressure: 0x3C held, 0xC3 stalls on its last bit
        b8.p_ready = 1'b0;
        send_word8(8'h3C);
        check("bp_full_valid", 32'(b8.p_valid), 32'd1);
        check("bp_full_data",  32'(b8.p_data),  32'h3C);
        w = 8'hC3;
        for (int i = 0; i < 7; i++) begin
            b8.s_valid = 1'b1;
            b8.s_data  = w[i];
            check("bp_partial_ready", 32'(b8.s_ready), 32'd1);
            tick();
        end
        b8.s_data = w[7];
        check("bp_stall_ready", 32'(b8.s_ready), 32'd0);
        tick();
        check("bp_hold_data",  32'(b8.p_data),  32'h3C);
        check("bp_hold_valid", 32'(b8.p_valid), 32'd1);
        b8.p_ready = 1'b1;
        tick();
        b8.p_ready = 1'b0;
        check("bp_drain_valid", 32'(b8.p_valid), 32'd0);
        check("bp_drain_ready", 32'(b8.s_ready), 32'd1);
        tick();
        b8.s_valid = 1'b0;
        check("bp_second_valid", 32'(b8.p_valid), 32'd1);
        check("bp_second_data",  32'(b8.p_data),  32'hC3);
        b8.p_ready = 1'b1;
        tick();
        check("bp_second_drain", 32'(b8.p_valid), 32'd0);

        // reset while FULL and mid-word
        b8.p_ready = 1'b0;
        send_word8(8'h3C);
        for (int i = 0; i < 4; i++) begin
            b8.s_valid = 1'b1;
            b8.s_data  = 1'b1;
            tick();
        end
        b8.s_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("rst_full_valid", 32'(b8.p_valid), 32'd0);
        check("rst_full_data",  32'(b8.p_data),  32'd0);
        check("rst_full_ready", 32'(b8.s_ready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        b8.p_ready = 1'b1;
        w = 8'h5A;
        nvalid = 0;
        seen = 8'h00;
        for (int i = 0; i < 12; i++) begin
            b8.s_valid = (i < 8);
            b8.s_data  = (i < 8) ? w[i[2:0]] : 1'b0;
            tick();
            if (b8.p_valid) begin
                nvalid++;
                seen = b8.p_data;
            end
        end
        check("rstmid_words", 32'(nvalid), 32'd1);
        check("rstmid_data",  32'(seen),   32'h5A);

        // randomized streams against the word-level reference
        sent = '{32'h00, 32'hFF, 32'h81, 32'h96};
        for (int k = 0; k < 6; k++) sent.push_back(int'($urandom_range(0, 255)));
        stream(0, 8);
        sent = '{32'h13, 32'h1F};
        for (int k = 0; k < 6; k++) sent.push_back(int'($urandom_range(0, 31)));
        stream(1, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/s2p.md
Name: s2p

Overview:
- Serial-to-parallel converter. It is the downstream neighbour of the p2s block and consumes its s_data/s_valid/s_ready stream.
- It assembles N serial bits, received LSB-first, into one N-bit word.
- It presents the word on a valid/ready parallel interface to the next consumer.
- It has a single-word output holding register, so serial reception continues while the parallel sink applies backpressure.

Parameters:
- N, 8, word width in bits; legal for any N >= 2, including non-powers of two.
- N_BITS (localparam), $clog2(N), bit counter width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- s_valid  input  1  serial bit on s_data is valid.
- s_data  input  1  serial data bit, LSB of each word first.
- s_ready  output  1  block will accept the serial bit this cycle.
- p_data  output  N  assembled parallel word.
- p_valid  output  1  p_data holds a complete, unconsumed word.
- p_ready  input  1  downstream accepts p_data this cycle.

Behaviour:
- Interface: one clock, clk; reset rstn is asynchronous and active-low.
- Reset values: count=0, shift_reg=0, p_data=0, p_valid=0, output state EMPTY. s_ready is therefore 1 out of reset.
- Bit acceptance: a bit is accepted when s_valid && s_ready at a rising edge. When s_valid=0, s_data is ignored and no state changes on the serial side.
- On each accepted bit:
  - shift_reg <= {s_data, shift_reg[N-1:1]}.
  - If count != N-1, count <= count+1.
- Word completion: an accepted bit with count == N-1. At that edge:
  - count <= 0 (explicit compare, no reliance on natural wrap).
  - p_data <= {s_data, shift_reg[N-1:1]}, so bit 0 is the first bit received.
  - p_valid <= 1.
- Latency: p_valid rises on the edge that accepts the Nth bit, i.e. it is visible the cycle after the Nth bit is presented.
- Output state machine (p_valid is the registered state):
  - EMPTY -> FULL on word completion.
  - FULL -> EMPTY on p_valid && p_ready.
  - Otherwise the state holds.
- Output hold: while FULL and p_ready=0, p_data and p_valid are stable.
- s_ready = !(count == N-1 && p_valid). It is driven only from registers; there is no combinational path from p_ready.
  - Partial-word bits 0..N-2 are always accepted, even while the output is FULL.
  - Only the completing bit stalls.
- Consequence of the s_ready rule: completion and drain in the same cycle is impossible. The drain edge empties the output, and the stalled Nth bit is accepted on the following edge. This costs at most one bubble per backpressured word.
- Sustained throughput with p_ready tied high: one word every N accepted bits, with no bubbles.
- Reset mid-word: the partial word is discarded. The first accepted bit after reset is bit 0 of a new word.
- Reset while FULL: the pending word is lost and p_valid=0.
- No framing or resynchronisation beyond reset. Word alignment is defined solely by the count of accepted bits since reset.

Decomposition:
- Package s2p_pkg:
  - typedef enum logic {EMPTY=0, FULL=1} out_state_t.
  - No other shared constants; N_BITS stays a local parameter.
- No sub-module; the block is a single module.
- The verification bench instantiates p2s -> s2p back-to-back as a loopback top. That wrapper is bench-only, not RTL.

Test Plan:
- Reset: assert rstn=0 mid-cycle (asynchronously) -> p_valid=0, p_data=0, s_ready=1 immediately, with no clock required.
- Basic word, N=8, p_ready=1: bits 1,0,1,0,0,1,0,1 on consecutive cycles with s_valid=1 -> p_data=8'hA5, p_valid high for exactly one cycle, beginning the cycle after the 8th bit.
- Gaps: same word 0xA5 with s_valid low for 3 cycles between bits 2 and 3 and between bits 6 and 7 -> p_data=8'hA5; ignored s_data toggling during gaps has no effect.
- Backpressure:
  - Setup: word 0x3C is FULL with p_ready=0, then 0xC3 is streamed.
  - Bits 0..6 are accepted.
  - At the 8th bit, s_ready=0 and p_data stays 0x3C.
  - Raise p_ready for 1 cycle -> next cycle p_valid=0 and s_ready=1.
  - The 8th bit is then accepted -> p_data=8'hC3.
- Reset mid-word: 4 bits of 0xFF, pulse rstn, then bits of 0x5A -> exactly one word, p_data=8'h5A.
- Loopback with p2s (N=8 and N=5):
  - N=8: words 0x00, 0xFF, 0x81, 0x96 with random p_ready -> identical ordered output, no loss or duplication.
  - N=5: 5'h13 and 5'h1F -> reproduced exactly.
